// File: rtl/gfp8_seq_pkg.sv
// Shared types and constants for the GFP8 NV dot sequencer and its
// accumulation datapath.
package gfp8_seq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // GFP value. Both fields are two's complement and are reinterpreted
  // with $signed wherever arithmetic needs it.
  typedef struct packed {
    logic [31:0] mantissa;
    logic [7:0]  exponent;
  } gfp_t;

  localparam logic [31:0] MANT_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] MANT_MIN    = 32'h8000_0000;
  localparam int          ALIGN_LIMIT = 31;

  // Arithmetic right shift of a mantissa by a non-negative exponent gap.
  // A gap wider than the mantissa flushes to zero, even for negative
  // values, so tiny terms never leave a -1 residue behind.
  function automatic logic [31:0] align_mant(input logic [31:0] mant,
                                             input logic [8:0]  gap);
    logic [31:0] res;
    if (int'(gap) > ALIGN_LIMIT) begin
      res = 32'd0;
    end else begin
      res = $signed(mant) >>> gap[4:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/gfp8_acc_align.sv
// Combinational GFP adder: aligns both operands to the larger exponent and
// adds the mantissas with signed 32-bit saturation.
module gfp8_acc_align
  import gfp8_seq_pkg::*;
(
  input  gfp_t a_gfp,
  input  gfp_t b_gfp,
  output gfp_t sum_gfp
);

  logic [7:0]  exp_max_s;
  logic [8:0]  gap_a_s;
  logic [8:0]  gap_b_s;
  logic [31:0] al_a_s;
  logic [31:0] al_b_s;
  logic [32:0] wide_s;
  logic [31:0] sat_s;

  // Align both operands to the common exponent and saturate the sum.
  always_comb begin
    if ($signed(a_gfp.exponent) >= $signed(b_gfp.exponent)) begin
      exp_max_s = a_gfp.exponent;
    end else begin
      exp_max_s = b_gfp.exponent;
    end
    // Sign-extended 9-bit differences; never negative since exp_max_s is the max.
    gap_a_s = {exp_max_s[7], exp_max_s} - {a_gfp.exponent[7], a_gfp.exponent};
    gap_b_s = {exp_max_s[7], exp_max_s} - {b_gfp.exponent[7], b_gfp.exponent};
    al_a_s  = align_mant(a_gfp.mantissa, gap_a_s);
    al_b_s  = align_mant(b_gfp.mantissa, gap_b_s);
    wide_s  = {al_a_s[31], al_a_s} + {al_b_s[31], al_b_s};
    if (wide_s[32] != wide_s[31]) begin
      if (wide_s[32]) begin
        sat_s = MANT_MIN;
      end else begin
        sat_s = MANT_MAX;
      end
    end else begin
      sat_s = wide_s[31:0];
    end
    sum_gfp.mantissa = sat_s;
    sum_gfp.exponent = exp_max_s;
  end

endmodule

// File: rtl/gfp8_nv_dot_sequencer.sv
// Streams a run of NV pairs from the tile BRAMs into the NV dot unit, one
// per cycle, and folds the returned GFP partials into one dot product.
module gfp8_nv_dot_sequencer
  import gfp8_seq_pkg::*;
#(
  parameter int NV_ADDR_W = 9,
  parameter int CNT_W     = 8,
  parameter int BRAM_LAT  = 1,
  parameter int DOT_LAT   = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [NV_ADDR_W-1:0] i_cmd_left_base,
  input  logic [NV_ADDR_W-1:0] i_cmd_right_base,
  input  logic [CNT_W-1:0]     i_cmd_num_nv,
  output logic                 o_rd_en,
  output logic [NV_ADDR_W-1:0] o_left_rd_addr,
  output logic [NV_ADDR_W-1:0] o_right_rd_addr,
  output logic                 o_dot_valid,
  input  logic signed [31:0]   i_dot_mantissa,
  input  logic signed [7:0]    i_dot_exponent,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic signed [31:0]   o_res_mantissa,
  output logic signed [7:0]    o_res_exponent,
  output logic                 o_busy
);

  // Read tokens travel through the BRAM and the dot unit; the last stage
  // marks the cycle in which the dot unit's output belongs to us.
  localparam int TOK_DEPTH = BRAM_LAT + DOT_LAT;

  seq_state_e           state_r;
  seq_state_e           state_next_s;
  logic                 accept_s;
  logic                 ret_s;
  logic [CNT_W-1:0]     num_nv_r;
  logic [CNT_W-1:0]     issue_cnt_r;
  logic [CNT_W-1:0]     ret_cnt_r;
  logic [CNT_W-1:0]     ret_cnt_next_s;
  logic [NV_ADDR_W-1:0] left_addr_r;
  logic [NV_ADDR_W-1:0] right_addr_r;
  logic [TOK_DEPTH-1:0] tok_r;
  logic                 rd_en_r;
  logic                 cmd_ready_r;
  logic                 busy_r;
  logic                 res_valid_r;
  logic                 acc_first_r;
  gfp_t                 acc_r;
  gfp_t                 dot_s;
  gfp_t                 sum_s;

  assign ret_s          = tok_r[TOK_DEPTH-1];
  assign ret_cnt_next_s = ret_cnt_r + {{(CNT_W-1){1'b0}}, ret_s};
  assign dot_s          = {i_dot_mantissa, i_dot_exponent};

  gfp8_acc_align u_align (
    .a_gfp   (acc_r),
    .b_gfp   (dot_s),
    .sum_gfp (sum_s)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and command acceptance.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_ready_r && i_cmd_valid) begin
          accept_s = 1'b1;
          if (i_cmd_num_nv == {CNT_W{1'b0}}) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_cnt_r == (num_nv_r - {{(CNT_W-1){1'b0}}, 1'b1})) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        // Leave as soon as the final return is being sampled so the result
        // is presented on the cycle right after it lands in the accumulator.
        if (ret_cnt_next_s == num_nv_r) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (i_res_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Registered status/strobe outputs derived from the upcoming state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      rd_en_r     <= 1'b0;
    end else begin
      cmd_ready_r <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      res_valid_r <= (state_next_s == ST_DONE);
      rd_en_r     <= (state_next_s == ST_ISSUE);
    end
  end

  // Command latch and address/issue counters; addresses wrap naturally.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      num_nv_r     <= {CNT_W{1'b0}};
      issue_cnt_r  <= {CNT_W{1'b0}};
      left_addr_r  <= {NV_ADDR_W{1'b0}};
      right_addr_r <= {NV_ADDR_W{1'b0}};
    end else if (accept_s) begin
      num_nv_r     <= i_cmd_num_nv;
      issue_cnt_r  <= {CNT_W{1'b0}};
      left_addr_r  <= i_cmd_left_base;
      right_addr_r <= i_cmd_right_base;
    end else if (state_r == ST_ISSUE) begin
      issue_cnt_r  <= issue_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      left_addr_r  <= left_addr_r + {{(NV_ADDR_W-1){1'b0}}, 1'b1};
      right_addr_r <= right_addr_r + {{(NV_ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      num_nv_r     <= num_nv_r;
      issue_cnt_r  <= issue_cnt_r;
      left_addr_r  <= left_addr_r;
      right_addr_r <= right_addr_r;
    end
  end

  // Token pipe: one bit per outstanding read, shifted every cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tok_r <= {TOK_DEPTH{1'b0}};
    end else begin
      tok_r <= (tok_r << 1) | {{(TOK_DEPTH-1){1'b0}}, rd_en_r};
    end
  end

  // Return counter and GFP accumulator.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ret_cnt_r   <= {CNT_W{1'b0}};
      acc_first_r <= 1'b0;
      acc_r       <= '{mantissa: 32'd0, exponent: 8'd0};
    end else if (accept_s) begin
      ret_cnt_r   <= {CNT_W{1'b0}};
      acc_first_r <= 1'b1;
      acc_r       <= '{mantissa: 32'd0, exponent: 8'd0};
    end else if (ret_s) begin
      ret_cnt_r   <= ret_cnt_next_s;
      acc_first_r <= 1'b0;
      if (acc_first_r) begin
        acc_r <= dot_s;
      end else begin
        acc_r <= sum_s;
      end
    end else begin
      ret_cnt_r   <= ret_cnt_r;
      acc_first_r <= acc_first_r;
      acc_r       <= acc_r;
    end
  end

  assign o_cmd_ready     = cmd_ready_r;
  assign o_busy          = busy_r;
  assign o_res_valid     = res_valid_r;
  assign o_rd_en         = rd_en_r;
  assign o_left_rd_addr  = left_addr_r;
  assign o_right_rd_addr = right_addr_r;
  assign o_dot_valid     = tok_r[BRAM_LAT-1];
  assign o_res_mantissa  = acc_r.mantissa;
  assign o_res_exponent  = acc_r.exponent;

endmodule

// File: tb/tb_gfp8_nv_dot_sequencer.sv
// Self-checking bench for gfp8_nv_dot_sequencer: a behavioural dot-unit
// model answers o_dot_valid after DOT_LAT cycles, and every command is
// checked cycle by cycle against timing and a plain-arithmetic GFP model.
module tb_gfp8_nv_dot_sequencer;

  localparam int NV_ADDR_W = 9;
  localparam int CNT_W     = 8;
  localparam int BRAM_LAT  = 1;
  localparam int DOT_LAT   = 3;
  localparam int RES_LAT   = BRAM_LAT + DOT_LAT + 1;
  localparam int PD        = DOT_LAT + 1;

  logic                 i_clk = 1'b0;
  logic                 i_reset_n = 1'b0;
  logic                 i_cmd_valid = 1'b0;
  logic                 o_cmd_ready;
  logic [NV_ADDR_W-1:0] i_cmd_left_base = '0;
  logic [NV_ADDR_W-1:0] i_cmd_right_base = '0;
  logic [CNT_W-1:0]     i_cmd_num_nv = '0;
  logic                 o_rd_en;
  logic [NV_ADDR_W-1:0] o_left_rd_addr;
  logic [NV_ADDR_W-1:0] o_right_rd_addr;
  logic                 o_dot_valid;
  logic signed [31:0]   i_dot_mantissa = '0;
  logic signed [7:0]    i_dot_exponent = '0;
  logic                 o_res_valid;
  logic                 i_res_ready = 1'b0;
  logic signed [31:0]   o_res_mantissa;
  logic signed [7:0]    o_res_exponent;
  logic                 o_busy;

  int n_vec = 0;
  int n_err = 0;

  // Results the dot-unit model hands out, in issue order.
  logic [31:0] dot_m_q[$];
  logic [7:0]  dot_e_q[$];
  // Per-command partials loaded by each test before run_cmd.
  logic [31:0] cm[$];
  logic [7:0]  ce[$];

  gfp8_nv_dot_sequencer #(
    .NV_ADDR_W (NV_ADDR_W),
    .CNT_W     (CNT_W),
    .BRAM_LAT  (BRAM_LAT),
    .DOT_LAT   (DOT_LAT)
  ) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_cmd_left_base  (i_cmd_left_base),
    .i_cmd_right_base (i_cmd_right_base),
    .i_cmd_num_nv     (i_cmd_num_nv),
    .o_rd_en          (o_rd_en),
    .o_left_rd_addr   (o_left_rd_addr),
    .o_right_rd_addr  (o_right_rd_addr),
    .o_dot_valid      (o_dot_valid),
    .i_dot_mantissa   (i_dot_mantissa),
    .i_dot_exponent   (i_dot_exponent),
    .o_res_valid      (o_res_valid),
    .i_res_ready      (i_res_ready),
    .o_res_mantissa   (o_res_mantissa),
    .o_res_exponent   (o_res_exponent),
    .o_busy           (o_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  // Dot-unit model: an input accepted with o_dot_valid in cycle j shows its
  // result on i_dot_* during cycle j+DOT_LAT; all other cycles carry junk.
  initial begin
    logic        pv[PD];
    logic [31:0] pm[PD];
    logic [7:0]  pe[PD];
    for (int k = 0; k < PD; k++) begin
      pv[k] = 1'b0; pm[k] = 32'd0; pe[k] = 8'd0;
    end
    forever begin
      @(negedge i_clk);
      for (int k = PD - 1; k > 0; k--) begin
        pv[k] = pv[k-1]; pm[k] = pm[k-1]; pe[k] = pe[k-1];
      end
      pv[0] = (o_dot_valid === 1'b1);
      if (pv[0] && dot_m_q.size() > 0) begin
        pm[0] = dot_m_q.pop_front();
        pe[0] = dot_e_q.pop_front();
      end else begin
        pm[0] = $urandom;
        pe[0] = 8'($urandom);
      end
      if (pv[PD-1]) begin
        i_dot_mantissa = pm[PD-1];
        i_dot_exponent = pe[PD-1];
      end else begin
        i_dot_mantissa = $urandom;
        i_dot_exponent = 8'($urandom);
      end
    end
  end

  // Floor division by 2^sh; gaps beyond 31 contribute nothing.
  function automatic longint ref_align(input longint m, input int sh);
    longint d, q;
    if (sh > 31) return 0;
    d = longint'(1) << sh;
    q = m / d;
    if (m < 0 && q * d != m) q = q - 1;
    return q;
  endfunction

  // Folds cm/ce into the expected GFP result.
  task automatic ref_model(output logic [31:0] em, output logic [7:0] ee);
    longint am = 0;
    int     ae = 0;
    for (int k = 0; k < cm.size(); k++) begin
      longint m = longint'($signed(cm[k]));
      int     e = int'($signed(ce[k]));
      if (k == 0) begin
        am = m; ae = e;
      end else begin
        int big = (ae > e) ? ae : e;
        am = ref_align(am, big - ae) + ref_align(m, big - e);
        if (am > 64'sd2147483647) am = 64'sd2147483647;
        if (am < -64'sd2147483648) am = -64'sd2147483648;
        ae = big;
      end
    end
    em = am[31:0];
    ee = 8'(ae);
  endtask

  // Issues one command from a negedge where the DUT should be idle, checks
  // every cycle up to the result, optionally stalls the consumer for `hold`
  // cycles (with stray commands if `spam`), then completes the handshake.
  task automatic run_cmd(input logic [8:0] lb, input logic [8:0] rb, input int n,
                         input int hold, input bit spam);
    logic [31:0] em;
    logic [7:0]  ee;
    int          rv_t;
    ref_model(em, ee);
    foreach (cm[k]) begin
      dot_m_q.push_back(cm[k]);
      dot_e_q.push_back(ce[k]);
    end
    n_vec++;
    if (o_cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL cmd_ready_idle got %b want 1", o_cmd_ready);
    end
    i_cmd_valid = 1'b1; i_cmd_left_base = lb; i_cmd_right_base = rb; i_cmd_num_nv = n[7:0];
    rv_t = (n == 0) ? 1 : n + RES_LAT;
    for (int t = 1; t <= rv_t; t++) begin
      logic       exp_rd, exp_dv;
      logic [8:0] ela, era;
      @(negedge i_clk);
      if (t == 1) begin
        i_cmd_valid = 1'b0;
        i_cmd_left_base = 9'($urandom); i_cmd_right_base = 9'($urandom);
        i_cmd_num_nv = 8'($urandom);
      end
      exp_rd = (t <= n);
      exp_dv = (t > BRAM_LAT) && (t <= n + BRAM_LAT);
      ela = lb + 9'(t - 1);
      era = rb + 9'(t - 1);
      n_vec++;
      if (o_rd_en !== exp_rd) begin
        n_err++; $display("FAIL rd_en t=%0d got %b want %b", t, o_rd_en, exp_rd);
      end
      n_vec++;
      if (o_dot_valid !== exp_dv) begin
        n_err++; $display("FAIL dot_valid t=%0d got %b want %b", t, o_dot_valid, exp_dv);
      end
      n_vec++;
      if (o_res_valid !== (t == rv_t)) begin
        n_err++; $display("FAIL res_valid_timing t=%0d got %b want %b", t, o_res_valid, (t == rv_t));
      end
      n_vec++;
      if (o_busy !== 1'b1 || o_cmd_ready !== 1'b0) begin
        n_err++; $display("FAIL busy_ready t=%0d got busy=%b ready=%b want 1/0", t, o_busy, o_cmd_ready);
      end
      if (exp_rd) begin
        n_vec++;
        if (o_left_rd_addr !== ela || o_right_rd_addr !== era) begin
          n_err++;
          $display("FAIL rd_addr t=%0d got %0d/%0d want %0d/%0d", t, o_left_rd_addr, o_right_rd_addr, ela, era);
        end
      end
    end
    n_vec++;
    if (o_res_mantissa !== em || o_res_exponent !== ee) begin
      n_err++; $display("FAIL result n=%0d got (%h,%0d) want (%h,%0d)", n, o_res_mantissa, o_res_exponent, em, $signed(ee));
    end
    for (int h = 0; h < hold; h++) begin
      if (spam) begin
        i_cmd_valid = 1'b1; i_cmd_num_nv = 8'd3;
        i_cmd_left_base = 9'($urandom); i_cmd_right_base = 9'($urandom);
      end
      @(negedge i_clk);
      n_vec++;
      if (o_res_valid !== 1'b1 || o_res_mantissa !== em || o_res_exponent !== ee || o_cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold h=%0d got v=%b (%h,%0d) rdy=%b want v=1 (%h,%0d) rdy=0",
                 h, o_res_valid, o_res_mantissa, o_res_exponent, o_cmd_ready, em, $signed(ee));
      end
    end
    i_cmd_valid = 1'b0;
    i_res_ready = 1'b1;
    @(negedge i_clk);
    i_res_ready = 1'b0;
    n_vec++;
    if (o_res_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL after_handshake got v=%b rdy=%b busy=%b rd=%b want 0/1/0/0", o_res_valid, o_cmd_ready, o_busy, o_rd_en);
    end
    cm.delete(); ce.delete();
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if (o_cmd_ready !== 1'b0 || o_rd_en !== 1'b0 || o_left_rd_addr !== 9'd0 || o_right_rd_addr !== 9'd0 ||
        o_dot_valid !== 1'b0 || o_res_valid !== 1'b0 || o_res_mantissa !== 32'sd0 ||
        o_res_exponent !== 8'sd0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s outputs got rdy=%b rd=%b la=%0d ra=%0d dv=%b rv=%b m=%h e=%h busy=%b want all 0",
               tag, o_cmd_ready, o_rd_en, o_left_rd_addr, o_right_rd_addr, o_dot_valid, o_res_valid,
               o_res_mantissa, o_res_exponent, o_busy);
    end
  endtask

  task automatic push_pair(input logic [31:0] m, input logic [7:0] e);
    cm.push_back(m); ce.push_back(e);
  endtask

  task automatic test_reset();
    #1;
    check_all_zero("reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    n_vec++;
    if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_res_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset got rdy=%b busy=%b rv=%b want 1/0/0", o_cmd_ready, o_busy, o_res_valid);
    end
  endtask

  task automatic test_single();
    push_pair(32'd100, 8'd5);
    run_cmd(9'd0, 9'd0, 1, 0, 1'b0);
  endtask

  task automatic test_align();
    push_pair(32'd64, 8'd3);
    push_pair(32'd32, 8'd5);
    run_cmd(9'd17, 9'd300, 2, 0, 1'b0);
  endtask

  task automatic test_saturation();
    push_pair(32'h7FFF_FFFF, 8'd0);
    push_pair(32'd1, 8'd0);
    run_cmd(9'd5, 9'd6, 2, 0, 1'b0);
    push_pair(32'h8000_0000, 8'd0);
    push_pair(32'hFFFF_FFFF, 8'd0);
    run_cmd(9'd5, 9'd6, 2, 0, 1'b0);
  endtask

  task automatic test_shift_limit();
    push_pair(32'd1000, 8'd0);
    push_pair(32'd7, 8'd40);
    run_cmd(9'd1, 9'd2, 2, 0, 1'b0);
    push_pair(32'hFFFF_FC18, 8'd0);
    push_pair(32'd7, 8'd40);
    run_cmd(9'd1, 9'd2, 2, 0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 4; k++) push_pair($urandom_range(0, 4000), 8'($urandom_range(0, 6)));
    run_cmd(9'd510, 9'd509, 4, 0, 1'b0);
  endtask

  task automatic test_zero_hold();
    run_cmd(9'd33, 9'd44, 0, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) push_pair($urandom, 8'($urandom_range(0, 8)));
      run_cmd(9'($urandom), 9'($urandom), n, 0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_issue();
    for (int k = 0; k < 8; k++) dot_m_q.push_back($urandom);
    for (int k = 0; k < 8; k++) dot_e_q.push_back(8'($urandom));
    i_cmd_valid = 1'b1; i_cmd_left_base = 9'd100; i_cmd_right_base = 9'd200; i_cmd_num_nv = 8'd8;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    #2 i_reset_n = 1'b0;
    #1 check_all_zero("reset_mid_issue");
    dot_m_q.delete(); dot_e_q.delete();
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge i_clk);
      n_vec++;
      if (o_res_valid !== 1'b0 || o_rd_en !== 1'b0 || o_dot_valid !== 1'b0) begin
        n_err++; $display("FAIL post_reset_quiet t=%0d got rv=%b rd=%b dv=%b want 0", t, o_res_valid, o_rd_en, o_dot_valid);
      end
    end
    push_pair(32'd12345, 8'hFE);
    run_cmd(9'd7, 9'd8, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 25; r++) begin
      int n    = $urandom_range(0, 12);
      int mode = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        if (mode == 0) push_pair($urandom, 8'($urandom));
        else if (mode == 1) push_pair($urandom, 8'($urandom_range(0, 6) - 3));
        else push_pair(32'($urandom_range(0, 2000)) - 32'd1000, 8'($urandom_range(0, 40) - 20));
      end
      run_cmd(9'($urandom), 9'($urandom), n, $urandom_range(0, 2), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_align();
    test_saturation();
    test_shift_limit();
    test_wrap();
    test_zero_hold();
    test_back_to_back();
    test_reset_mid_issue();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
